rv32i_cycle_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Steps each instruction through

---
 rtl/rv32i_cycle_sequencer.sv | 163 ++++++++++++++++
 tb/tb_rv32i_cycle_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rv32i_cycle_sequencer.sv
// Multi-cycle control FSM for the RV32I core: steps FETCH/DECODE/EXECUTE/MEM/WB,
// drives datapath strobes, and traps illegal opcodes and memory timeouts.
module rv32i_cycle_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel_data,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        instr_retired,
    output logic        fault,
    output logic [2:0]  state
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_FAULT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
    } class_t;

    state_t        cur, nxt;
    class_t        cls, cls_dec;
    logic          dec_ok;
    logic [CW-1:0] wcnt;
    logic          wait_expired;

    logic       req, we, sel, irw, pcw, pcs, rgw, ret, flt;
    logic [1:0] wbs;

    logic unused_instr_hi;
    assign unused_instr_hi = &{1'b0, instr[31:12]};

    always_comb begin
        cls_dec = C_R;
        dec_ok  = 1'b1;
        case (instr[6:0])
            7'b0110011: cls_dec = C_R;
            7'b0010011: cls_dec = C_I;
            7'b0000011: cls_dec = C_LOAD;
            7'b0100011: cls_dec = C_STORE;
            7'b1100011: cls_dec = C_BRANCH;
            7'b1101111: cls_dec = C_JAL;
            7'b1100111: cls_dec = C_JALR;
            7'b0110111: cls_dec = C_LUI;
            7'b0010111: cls_dec = C_AUIPC;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // The counter holds completed wait cycles, so this cycle is the TIMEOUT-th one.
    assign wait_expired = (wcnt == CW'(TIMEOUT - 1));

    always_comb begin
        nxt = cur;
        req = 1'b0; we  = 1'b0; sel = 1'b0; irw = 1'b0;
        pcw = 1'b0; pcs = 1'b0; rgw = 1'b0; ret = 1'b0;
        flt = 1'b0; wbs = 2'b00;
        case (cur)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    irw = 1'b1;
                    nxt = S_DECODE;
                end else if (wait_expired) begin
                    nxt = S_FAULT;
                end
            end
            S_DECODE: nxt = dec_ok ? S_EXECUTE : S_FAULT;
            S_EXECUTE: begin
                case (cls)
                    C_BRANCH: begin
                        pcw = 1'b1;
                        pcs = branch_taken;
                        ret = 1'b1;
                        nxt = S_FETCH;
                    end
                    C_LOAD, C_STORE: nxt = S_MEM;
                    default:         nxt = S_WB;
                endcase
            end
            S_MEM: begin
                req = 1'b1;
                sel = 1'b1;
                we  = (cls == C_STORE);
                if (mem_ready) begin
                    if (cls == C_STORE) begin
                        pcw = 1'b1;
                        ret = 1'b1;
                        nxt = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (wait_expired) begin
                    nxt = S_FAULT;
                end
            end
            S_WB: begin
                rgw = (instr[11:7] != 5'd0);
                pcw = 1'b1;
                ret = 1'b1;
                nxt = S_FETCH;
                if (cls == C_JAL || cls == C_JALR) begin
                    pcs = 1'b1;
                    wbs = 2'b10;
                end else if (cls == C_LOAD) begin
                    wbs = 2'b01;
                end
            end
            S_FAULT: flt = 1'b1;
            default: nxt = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= S_FETCH;
            cls  <= C_R;
            wcnt <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE && dec_ok)
                cls <= cls_dec;
            if ((nxt == S_FETCH || nxt == S_MEM) && nxt != cur)
                wcnt <= '0;
            else if (mem_ready)
                wcnt <= '0;
            else if (req)
                wcnt <= wcnt + CW'(1);
        end
    end

    // Reset holds state at FETCH, so strobes are gated to stay quiet during it.
    assign mem_req       = rst_n & req;
    assign mem_we        = rst_n & we;
    assign mem_sel_data  = rst_n & sel;
    assign ir_we         = rst_n & irw;
    assign pc_we         = rst_n & pcw;
    assign pc_sel        = rst_n & pcs;
    assign reg_we        = rst_n & rgw;
    assign wb_sel        = rst_n ? wbs : 2'b00;
    assign instr_retired = rst_n & ret;
    assign fault         = rst_n & flt;
    assign state         = cur;

endmodule

// File: tb/tb_rv32i_cycle_sequencer.sv
// Directed table-driven bench for rv32i_cycle_sequencer, plus zero-wait latency runs.
module tb_rv32i_cycle_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_sel, reg_we;
    logic [1:0]  wb_sel;
    logic        instr_retired, fault;
    logic [2:0]  state;

    rv32i_cycle_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel_data(mem_sel_data), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .instr_retired(instr_retired),
        .fault(fault), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_sel, reg_we, wb_sel, retired, fault}
    localparam logic [10:0] NONE = 11'h000, REQ = 11'h400, WE  = 11'h200, SEL = 11'h100,
                            IRW  = 11'h080, PCW = 11'h040, PCS = 11'h020, RGW = 11'h010,
                            WBP  = 11'h008, WBM = 11'h004, RET = 11'h002, FLT = 11'h001;
    localparam logic [2:0]  F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, X = 3'd7;

    localparam logic [31:0] ADD  = 32'h002081B3, LW  = 32'h0000A103, SW  = 32'h0020A023,
                            BEQ  = 32'h00208463, JAL = 32'h0080006F, JALR = 32'h000080E7,
                            LUI  = 32'h123450B7, ILL = 32'h00000000;

    typedef struct {
        string       tag;
        logic        rst;
        logic [31:0] ins;
        logic        rdy;
        logic        bt;
        logic [2:0]  st;
        logic [10:0] o;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;
    logic [10:0] got;

    assign got = {mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_sel, reg_we,
                  wb_sel, instr_retired, fault};

    function automatic void add(input string tag, input logic rst, input logic [31:0] ins,
                                input logic rdy, input logic bt, input logic [2:0] st,
                                input logic [10:0] o);
        vec_t v;
        v.tag = tag; v.rst = rst; v.ins = ins; v.rdy = rdy; v.bt = bt; v.st = st; v.o = o;
        vq.push_back(v);
    endfunction

    task automatic lat(input string name, input logic [31:0] ins, input int exp_l);
        int n;
        n = 0;
        for (int c = 1; c <= 20 && n == 0; c++) begin
            @(negedge clk);
            instr = ins; mem_ready = 1'b1; branch_taken = 1'b1;
            #1;
            if (instr_retired) n = c;
        end
        tests++;
        if (n != exp_l) begin
            fails++;
            $display("FAIL latency %s: got %0d cycles (0 = no retire within 20), want %0d",
                     name, n, exp_l);
        end
    endtask

    initial begin
        rst_n = 1'b0; instr = '0; mem_ready = 1'b0; branch_taken = 1'b0;

        add("rst0", 0, ILL, 0, 0, F, NONE);
        add("rst1", 0, ILL, 1, 0, F, NONE);
        // ADD with two wait cycles before ready
        add("add_f1", 1, ADD, 0, 0, F, REQ);
        add("add_f2", 1, ADD, 0, 0, F, REQ);
        add("add_f3", 1, ADD, 1, 0, F, REQ | IRW);
        add("add_d",  1, ADD, 0, 0, D, NONE);
        add("add_e",  1, ADD, 0, 0, E, NONE);
        add("add_wb", 1, ADD, 0, 0, W, PCW | RGW | RET);
        // LW, mem_ready in EXECUTE must be ignored
        add("lw_f",  1, LW, 1, 0, F, REQ | IRW);
        add("lw_d",  1, LW, 0, 0, D, NONE);
        add("lw_e",  1, LW, 1, 0, E, NONE);
        add("lw_m1", 1, LW, 0, 0, M, REQ | SEL);
        add("lw_m2", 1, LW, 1, 0, M, REQ | SEL);
        add("lw_wb", 1, LW, 0, 0, W, PCW | RGW | WBM | RET);
        // SW
        add("sw_f",  1, SW, 1, 0, F, REQ | IRW);
        add("sw_d",  1, SW, 0, 0, D, NONE);
        add("sw_e",  1, SW, 0, 0, E, NONE);
        add("sw_m1", 1, SW, 0, 0, M, REQ | WE | SEL);
        add("sw_m2", 1, SW, 1, 0, M, REQ | WE | SEL | PCW | RET);
        // BEQ taken / not taken
        add("beqt_f", 1, BEQ, 1, 1, F, REQ | IRW);
        add("beqt_d", 1, BEQ, 0, 1, D, NONE);
        add("beqt_e", 1, BEQ, 0, 1, E, PCW | PCS | RET);
        add("beqn_f", 1, BEQ, 1, 1, F, REQ | IRW);
        add("beqn_d", 1, BEQ, 0, 1, D, NONE);
        add("beqn_e", 1, BEQ, 0, 0, E, PCW | RET);
        // JAL rd=0, JALR rd=1, LUI rd=1
        add("jal_f",  1, JAL, 1, 0, F, REQ | IRW);
        add("jal_d",  1, JAL, 0, 0, D, NONE);
        add("jal_e",  1, JAL, 0, 0, E, NONE);
        add("jal_wb", 1, JAL, 0, 0, W, PCW | PCS | WBP | RET);
        add("jalr_f", 1, JALR, 1, 0, F, REQ | IRW);
        add("jalr_d", 1, JALR, 0, 0, D, NONE);
        add("jalr_e", 1, JALR, 0, 0, E, NONE);
        add("jalr_wb",1, JALR, 0, 0, W, PCW | PCS | RGW | WBP | RET);
        add("lui_f",  1, LUI, 1, 0, F, REQ | IRW);
        add("lui_d",  1, LUI, 0, 0, D, NONE);
        add("lui_e",  1, LUI, 0, 0, E, NONE);
        add("lui_wb", 1, LUI, 0, 0, W, PCW | RGW | RET);
        // Reset during store MEM, then FETCH timeout after 4 wait cycles
        add("rs_f",   1, SW, 1, 0, F, REQ | IRW);
        add("rs_d",   1, SW, 0, 0, D, NONE);
        add("rs_e",   1, SW, 0, 0, E, NONE);
        add("rs_m",   1, SW, 0, 0, M, REQ | WE | SEL);
        add("rs_rst", 0, SW, 1, 0, F, NONE);
        add("to_w1",  1, SW, 0, 0, F, REQ);
        add("to_w2",  1, SW, 0, 0, F, REQ);
        add("to_w3",  1, SW, 0, 0, F, REQ);
        add("to_w4",  1, SW, 0, 0, F, REQ);
        add("to_flt1",1, SW, 1, 0, X, FLT);
        add("to_flt2",1, SW, 0, 0, X, FLT);
        add("to_flt3",1, SW, 1, 0, X, FLT);
        // Ready on the 4th wait cycle wins, then illegal opcode traps
        add("rdy_rst",1'b0, ILL, 0, 0, F, NONE);
        add("rdy_w1", 1, ILL, 0, 0, F, REQ);
        add("rdy_w2", 1, ILL, 0, 0, F, REQ);
        add("rdy_w3", 1, ILL, 0, 0, F, REQ);
        add("rdy_w4", 1, ILL, 1, 0, F, REQ | IRW);
        add("ill_d",  1, ILL, 0, 0, D, NONE);
        for (int i = 0; i < 100; i++)
            add("ill_hold", 1, ILL, logic'(i % 2), logic'((i / 2) % 2), X, FLT);
        add("rec_rst", 0, ILL, 1, 0, F, NONE);
        add("rec_rel", 1, ILL, 0, 0, F, REQ);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n = vq[i].rst; instr = vq[i].ins;
            mem_ready = vq[i].rdy; branch_taken = vq[i].bt;
            #1;
            tests++;
            if ({state, got} !== {vq[i].st, vq[i].o}) begin
                fails++;
                $display("FAIL vec %0d %s: got state=%0d out=%b, want state=%0d out=%b",
                         i, vq[i].tag, state, got, vq[i].st, vq[i].o);
            end
        end

        // Zero-wait latencies, back to back from FETCH
        lat("beq", BEQ, 3);
        lat("add", ADD, 4);
        lat("sw",  SW,  4);
        lat("lw",  LW,  5);
        lat("jal", JAL, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
